// File: rtl/trng_word_packer_if.sv
// trng_word_packer_if: valid/ready word channel from the packer to the system side.
interface trng_word_packer_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_ready;
    modport master(output word_out, output word_valid, input word_ready);
    modport slave(input word_out, input word_valid, output word_ready);
endinterface

// File: rtl/trng_word_packer.sv
// trng_word_packer: optional von Neumann debias, packs bits into WORD_W words on a valid/ready channel.
// Optional repetition-count health test is built when TRNG_HEALTH_TEST_EN is defined.
module trng_word_packer #(
    parameter int WORD_W    = 8,
    parameter int DEBIAS    = 1,
    parameter int RCT_LIMIT = 32
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               en,
    input  logic               bit_in,
    input  logic               bit_vld,
    trng_word_packer_if.master wo,
    output logic               overrun,
    output logic [7:0]         ovr_cnt,
    output logic               health_fail
);
    localparam int CW = $clog2(WORD_W + 1);
    localparam logic [0:0] PAIR_A = 1'b0;
    localparam logic [0:0] PAIR_B = 1'b1;
    logic [0:0]        pair_q, pair_d;
    logic              first_q, first_d;
    logic [WORD_W-1:0] asm_q, asm_d, word_q, word_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              valid_q, valid_d, ovr_q, ovr_d;
    logic [7:0]        ovr_cnt_q, ovr_cnt_d;
    logic              take, emit_raw, emit_bit, emit, done, load, blocked;
    assign take = en & bit_vld;
    always_comb begin
        emit_raw  = DEBIAS != 0 ? take & (pair_q == PAIR_B) & (first_q != bit_in) : take;
        emit_bit  = DEBIAS != 0 ? first_q : bit_in;
        emit      = emit_raw & ~blocked;
        pair_d    = (DEBIAS == 0 || !en) ? PAIR_A : take ? ~pair_q : pair_q;
        first_d   = (take && pair_q == PAIR_A) ? bit_in : first_q;
        done      = emit && cnt_q == CW'(WORD_W - 1);
        asm_d     = emit ? {asm_q[WORD_W-2:0], emit_bit} : asm_q;
        cnt_d     = !emit ? cnt_q : done ? '0 : cnt_q + 1'b1;
        load      = done & (~valid_q | wo.word_ready);
        word_d    = load ? asm_d : word_q;
        valid_d   = load | (valid_q & ~wo.word_ready);
        ovr_d     = ovr_q | (done & ~load);
        ovr_cnt_d = ovr_cnt_q + {7'd0, done & ~load & (ovr_cnt_q != 8'hFF)};
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            pair_q    <= PAIR_A;
            first_q   <= 1'b0;
            asm_q     <= '0;
            cnt_q     <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
            ovr_cnt_q <= 8'd0;
        end else begin
            pair_q    <= pair_d;
            first_q   <= first_d;
            asm_q     <= asm_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
            ovr_cnt_q <= ovr_cnt_d;
        end
    end
`ifdef TRNG_HEALTH_TEST_EN
    // Counts raw (pre-debias) repeats; a zero count means no bit seen yet.
    logic [7:0] rct_q, rct_d;
    logic       last_q, last_d, hf_q, hf_d;
    always_comb begin
        rct_d  = !take ? rct_q : (rct_q != 8'd0 && bit_in == last_q) ? rct_q + {7'd0, rct_q != 8'hFF} : 8'd1;
        last_d = take ? bit_in : last_q;
        hf_d   = hf_q | (take && rct_d == 8'(RCT_LIMIT));
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            rct_q  <= 8'd0;
            last_q <= 1'b0;
            hf_q   <= 1'b0;
        end else begin
            rct_q  <= rct_d;
            last_q <= last_d;
            hf_q   <= hf_d;
        end
    end
    assign blocked     = hf_q;
    assign health_fail = hf_q;
`else
    logic unused_rct;
    assign unused_rct  = (RCT_LIMIT > 0);
    assign blocked     = 1'b0;
    assign health_fail = 1'b0;
`endif
    assign wo.word_out   = word_q;
    assign wo.word_valid = valid_q;
    assign overrun       = ovr_q;
    assign ovr_cnt       = ovr_cnt_q;
endmodule

// File: doc/trng_word_packer.md
Name: trng_word_packer

Overview:
- Downstream consumer of the TRNG core's 1-bit registered random output (`rand_num`).
- Optionally applies von Neumann debiasing to the raw bit stream.
- Packs surviving bits into WORD_W-bit words and presents them on a valid/ready interface to the system side (bus slave or FIFO).
- Tracks dropped words. An optional repetition-count health test flags a stuck entropy source.

Parameters:
- WORD_W, 8, output word width in bits; legal range 2..64.
- DEBIAS, 1, 1 = von Neumann correction enabled; 0 = every valid raw bit is used directly.
- RCT_LIMIT, 32, consecutive identical raw bits that trip the health test; legal range 2..255. Only used when the health macro is defined.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- clr  input  1  synchronous, active-high reset.
- en  input  1  packer enable; connects to the same en that drives the TRNG core.
- bit_in  input  1  raw random bit (TRNG rand_num).
- bit_vld  input  1  bit_in is a fresh sample this cycle; the top level drives it with en delayed by one cycle.
- word_out  output  WORD_W  assembled random word.
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  consumer accepts word_out.
- overrun  output  1  sticky; at least one completed word was dropped.
- ovr_cnt  output  8  count of dropped words, saturating at 255.
- health_fail  output  1  sticky repetition-count failure.

Behaviour:
- Reset:
  - clr=1 at a rising edge clears everything: word_out=0, word_valid=0, overrun=0, ovr_cnt=0, health_fail=0, pairing state=PAIR_A, assembly register=0, bit count=0, repetition counter=0.
  - clr has priority over all other inputs.
  - clr asserted mid-word discards the partial word and any half pair.
- Sample qualification: a raw bit is consumed only on a rising edge where en=1 and bit_vld=1.
- en=0: pairing state returns to PAIR_A and any half pair is discarded. The partial word, the output register and the handshake are unaffected; word_valid/word_ready still operate.
- Pairing FSM (DEBIAS=1):
  - PAIR_A: on a consumed bit, store it in first_bit and go to PAIR_B.
  - PAIR_B: on a consumed bit b, return to PAIR_A.
    - first_bit != b: emit first_bit (pair 01 emits 0, pair 10 emits 1).
    - first_bit == b: emit nothing.
- DEBIAS=0: every consumed bit is emitted in the same cycle; the FSM stays in PAIR_A.
- Assembly:
  - Each emitted bit shifts in at the LSB: asm <= {asm[WORD_W-2:0], bit}. The first emitted bit ends up at the MSB.
  - Bit count width is clog2(WORD_W+1).
  - When the emitted bit brings the count to WORD_W, the word is complete on that edge and the count resets to 0.
- Output handoff:
  - A transfer occurs on any edge with word_valid=1 and word_ready=1. word_valid drops unless a new word loads on the same edge.
  - A completed word loads into word_out, with word_valid=1, on the same edge if word_valid=0 or a transfer happens on that edge.
  - Otherwise the completed word is dropped: overrun<=1 and ovr_cnt increments (saturating at 255). word_out and word_valid hold unchanged.
  - word_out is stable while word_valid=1 and word_ready=0.
- Latency: word_valid is high in the cycle following the edge that consumed the final contributing raw bit.
- word_ready while word_valid=0 is ignored.

Optional Feature:
- Macro: TRNG_HEALTH_TEST_EN.
- Defined:
  - A raw repetition counter tracks consumed bits before debiasing. It resets to 1 whenever a consumed bit differs from the previous consumed bit and increments when it equals it.
  - When the count reaches RCT_LIMIT, health_fail<=1, sticky until clr.
  - While health_fail=1, no bits are emitted into assembly and no new words complete. A word already in word_out may still be drained.
- Undefined: no counter is built, health_fail is tied to 0, and emission is never blocked.

Test Plan:
- DEBIAS=1, WORD_W=8, word_ready=1. Feed 16 valid raw bits as pairs 10,01,10,01,01,10,01,10 -> word_valid=1 for one cycle, starting the cycle after the 16th bit; word_out=8'hA5; overrun=0.
- DEBIAS=1. Feed pairs 00,11,10,00,01 -> only two bits emitted (1,0); bit count=2; word_valid stays 0.
- word_ready=0. Feed two complete words, 8'hA5 then 8'h3C -> word_out stays 8'hA5 with word_valid=1; overrun=1; ovr_cnt=1. Then raise word_ready for one cycle -> word_valid=0.
- Assert clr after 5 valid raw bits, then feed the 16-bit 8'hA5 sequence -> word_out=8'hA5 with no residue from the pre-reset bits; all flags 0.
- DEBIAS=0. Feed 1,0,1,0,0,1,0,1 on consecutive cycles with en toggling low once mid-stream -> word_out=8'hA5. Bits presented while en=0 are ignored.
- TRNG_HEALTH_TEST_EN defined, RCT_LIMIT=32. Feed 32 consecutive 1s -> health_fail=1 the cycle after the 32nd bit. Then a valid 10/01 pattern produces no further word_valid until clr.
